// File: rtl/vending_pkg.sv
// Shared constants and state encoding for the two-product drink vending controller.
package vending_pkg;
   localparam int PRICE       = 45;
   localparam int NICKEL_VAL  = 5;
   localparam int DIME_VAL    = 10;
   localparam int QUARTER_VAL = 25;
   localparam int CREDIT_W    = 6;

   typedef enum logic {
      COLLECT = 1'b0,
      READY   = 1'b1
   } state_e;
endpackage

// File: rtl/vending_machine_coin_adder.sv
// Combinational coin summation with a credit add that saturates at the product price.
module coin_adder
   import vending_pkg::*;
(
   input  logic [CREDIT_W-1:0] credit_i,
   input  logic                quarter_i,
   input  logic                nickel_i,
   input  logic                dime_i,
   output logic [CREDIT_W-1:0] credit_o
);

   // One extra bit of headroom so credit plus a full coin sum can never wrap before clamping.
   localparam logic [CREDIT_W:0] QUARTER_W = (CREDIT_W+1)'(QUARTER_VAL);
   localparam logic [CREDIT_W:0] NICKEL_W  = (CREDIT_W+1)'(NICKEL_VAL);
   localparam logic [CREDIT_W:0] DIME_W    = (CREDIT_W+1)'(DIME_VAL);
   localparam logic [CREDIT_W:0] PRICE_W   = (CREDIT_W+1)'(PRICE);

   logic [CREDIT_W:0] coin_sum;
   logic [CREDIT_W:0] total;

   always_comb begin
      coin_sum = '0;
      if (quarter_i) coin_sum = coin_sum + QUARTER_W;
      if (nickel_i)  coin_sum = coin_sum + NICKEL_W;
      if (dime_i)    coin_sum = coin_sum + DIME_W;
      total    = {1'b0, credit_i} + coin_sum;
      credit_o = (total >= PRICE_W) ? PRICE_W[CREDIT_W-1:0] : total[CREDIT_W-1:0];
   end

endmodule

// File: rtl/vending_machine.sv
// Coin-accumulating vend controller: credit register, COLLECT/READY state and one-cycle dispense pulses.
module vending_machine
   import vending_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                quarter,
   input  logic                nickel,
   input  logic                dime,
   input  logic                soda,
   input  logic                diet,
   output logic                Give_soda,
   output logic                Give_diet,
   output logic [CREDIT_W-1:0] credit
);

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] credit_d;
   logic                give_soda_q;
   logic                give_diet_q;
   state_e              state;

   coin_adder u_coin_adder (
      .credit_i  (credit_q),
      .quarter_i (quarter),
      .nickel_i  (nickel),
      .dime_i    (dime),
      .credit_o  (credit_d)
   );

   // Credit saturates at the price, so the state is simply "credit has reached the price".
   assign state = (credit_q >= PRICE_C) ? READY : COLLECT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q    <= '0;
         give_soda_q <= 1'b0;
         give_diet_q <= 1'b0;
      end else begin
         give_soda_q <= 1'b0;
         give_diet_q <= 1'b0;
         case (state)
            READY: begin
               // Soda wins a simultaneous press; coins in the vend cycle are discarded.
               if (soda || diet) begin
                  credit_q    <= '0;
                  give_soda_q <= soda;
                  give_diet_q <= !soda;
               end else begin
                  credit_q <= credit_d;
               end
            end
            default: credit_q <= credit_d;
         endcase
      end
   end

   assign Give_soda = give_soda_q;
   assign Give_diet = give_diet_q;
   assign credit    = credit_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine with a queue of expected post-edge results.
module tb_vending_machine;
   import vending_pkg::*;

   logic                clk;
   logic                rst_n;
   logic                quarter;
   logic                nickel;
   logic                dime;
   logic                soda;
   logic                diet;
   logic                Give_soda;
   logic                Give_diet;
   logic [CREDIT_W-1:0] credit;

   typedef struct {
      string tag;
      int    credit;
      int    gsoda;
      int    gdiet;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   vending_machine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .quarter   (quarter),
      .nickel    (nickel),
      .dime      (dime),
      .soda      (soda),
      .diet      (diet),
      .Give_soda (Give_soda),
      .Give_diet (Give_diet),
      .credit    (credit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      checks++;
      assert (obs === 32'(expv))
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag, input int ec, input int es, input int ed);
      chk({tag, ".credit"}, 32'(credit), ec);
      chk({tag, ".Give_soda"}, 32'(Give_soda), es);
      chk({tag, ".Give_diet"}, 32'(Give_diet), ed);
   endtask

   // Drive one cycle of inputs, queue the expected result, then compare after the edge.
   task automatic cyc(input string tag, input logic q, input logic n, input logic d,
                      input logic s, input logic dt, input int ec, input int es, input int ed);
      exp_t e;
      quarter = q; nickel = n; dime = d; soda = s; diet = dt;
      e.tag = tag; e.credit = ec; e.gsoda = es; e.gdiet = ed;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_outputs(e.tag, e.credit, e.gsoda, e.gdiet);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      quarter = 1'b0; nickel = 1'b0; dime = 1'b0; soda = 1'b0; diet = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         quarter = 1'($urandom); nickel = 1'($urandom); dime = 1'($urandom);
         soda = 1'($urandom); diet = 1'($urandom);
         @(posedge clk);
         #1;
         check_outputs($sformatf("rst_hold%0d", i), 0, 0, 0);
      end
      @(negedge clk);
      quarter = 1'b0; nickel = 1'b0; dime = 1'b0; soda = 1'b0; diet = 1'b0;
      rst_n = 1'b1;
      cyc("rst_release", 0, 0, 0, 0, 0, 0, 0, 0);

      // Saturate and vend soda
      cyc("q1",        1, 0, 0, 0, 0, 25, 0, 0);
      cyc("idle1",     0, 0, 0, 0, 0, 25, 0, 0);
      cyc("q2_sat",    1, 0, 0, 0, 0, 45, 0, 0);
      cyc("n_swallow", 0, 1, 0, 0, 0, 45, 0, 0);
      cyc("vend_soda", 0, 0, 0, 1, 0, 0, 1, 0);
      cyc("post_soda", 0, 0, 0, 0, 0, 0, 0, 0);

      // Insufficient credit then top-up, diet vend
      cyc("q_n",       1, 1, 0, 0, 0, 30, 0, 0);
      cyc("n35",       0, 1, 0, 0, 0, 35, 0, 0);
      cyc("diet_low",  0, 0, 0, 0, 1, 35, 0, 0);
      cyc("d45",       0, 0, 1, 0, 0, 45, 0, 0);
      cyc("vend_diet", 0, 0, 0, 0, 1, 0, 0, 1);
      cyc("post_diet", 0, 0, 0, 0, 0, 0, 0, 0);

      // Selection with low credit while a coin arrives still accumulates
      cyc("sel_coin",  0, 0, 1, 1, 0, 10, 0, 0);
      cyc("to35",      1, 0, 0, 0, 0, 35, 0, 0);
      cyc("to45",      0, 0, 1, 0, 0, 45, 0, 0);

      // Dual selection, then held buttons
      cyc("dual",      0, 0, 0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++)
         cyc($sformatf("dual_hold%0d", i), 0, 0, 0, 1, 1, 0, 0, 0);

      // Vend cycle discards coins
      cyc("q_a",       1, 0, 0, 0, 0, 25, 0, 0);
      cyc("q_b",       1, 0, 0, 0, 0, 45, 0, 0);
      cyc("vend_coin", 1, 0, 0, 1, 0, 0, 1, 0);
      cyc("after_vc",  0, 0, 0, 0, 0, 0, 0, 0);

      // Zero credit selection
      cyc("zero_s0",   0, 0, 0, 1, 0, 0, 0, 0);
      cyc("zero_s1",   0, 0, 0, 1, 0, 0, 0, 0);

      // Asynchronous reset mid-operation
      cyc("m_q",       1, 0, 0, 0, 0, 25, 0, 0);
      cyc("m_d",       0, 0, 1, 0, 0, 35, 0, 0);
      quarter = 1'b0; dime = 1'b0; soda = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("async_rst", 0, 0, 0);
      #3;
      rst_n = 1'b1;
      cyc("after_rst", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("after_n",   0, 1, 0, 0, 0, 5, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
